// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Time-multiplexed driver for a common-anode 7-segment display.
//               Scans DIGITS packed hex nibbles, one slot of SCAN_DIV clocks
//               per digit. Exports a per-digit tick strobe and a frame strobe.
//               The digit values are captured once per frame, so changes in
//               the middle of a frame never tear the display.
//               Optional macro SEG7_LZB_EN enables leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   dat,
    input  logic [DIGITS-1:0]     dp,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic [DIGITS-1:0]     an,
    output logic                  tick,
    output logic                  frame
);

    localparam int c_PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(SCAN_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DIGITS - 1);
    localparam logic [c_PRE_W-1:0] c_PRE_ONE  = c_PRE_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    logic [c_PRE_W-1:0]   r_pre;
    logic [c_IDX_W-1:0]   r_idx;
    logic [4*DIGITS-1:0]  r_snap;
    logic                 r_tick;
    logic                 r_frame;
    logic [6:0]           r_seg;
    logic                 r_seg_dp;
    logic [DIGITS-1:0]    r_an;

    logic                 w_wrap;
    logic [3:0]           w_digit;
    logic                 w_dp;
    logic [DIGITS-1:0]    w_an;
    logic                 w_blank;

    // Hex nibble to active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Slot boundary: only counts while scanning is enabled
    assign w_wrap = en && (r_pre == c_PRE_LAST);

    // Prescaler, digit index, strobes and the once-per-frame snapshot
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_pre   <= '0;
            r_idx   <= '0;
            r_snap  <= '0;
            r_tick  <= 1'b0;
            r_frame <= 1'b0;
        end else begin
            r_tick  <= 1'b0;
            r_frame <= 1'b0;
            if (w_wrap) begin
                r_pre  <= '0;
                r_tick <= 1'b1;
                if (r_idx == c_IDX_LAST) begin
                    // Wrapping to digit 0 is the only point the display
                    // contents change, which keeps a frame self-consistent
                    r_idx   <= '0;
                    r_frame <= 1'b1;
                    r_snap  <= dat;
                end else begin
                    r_idx <= r_idx + c_IDX_ONE;
                end
            end else if (en) begin
                r_pre <= r_pre + c_PRE_ONE;
            end
        end
    end

    // Select the current digit's nibble, decimal point and anode
    always_comb begin
        w_digit = 4'h0;
        w_dp    = 1'b0;
        w_an    = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_digit = r_snap[4*i +: 4];
                w_dp    = dp[i];
                w_an[i] = 1'b0;
            end
        end
    end

`ifdef SEG7_LZB_EN
    // Blank digit i>0 when it and every more-significant digit are zero;
    // digit 0 is excluded so a zero value still shows "0"
    always_comb begin
        w_blank = 1'b0;
        for (int i = 1; i < DIGITS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_blank = ((r_snap >> (4*i)) == '0);
            end
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    // Registered output stage, one clock behind the digit index
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_an     <= '1;
            r_seg    <= 7'h7F;
            r_seg_dp <= 1'b1;
        end else begin
            r_an     <= w_an;
            r_seg    <= w_blank ? 7'h7F : hex7(w_digit);
            r_seg_dp <= ~w_dp;
        end
    end

    assign seg    = r_seg;
    assign seg_dp = r_seg_dp;
    assign an     = r_an;
    assign tick   = r_tick;
    assign frame  = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Directed self-checking bench for seg7_scan_driver with
//               DIGITS=4, SCAN_DIV=4. Expected segment values follow the
//               SEG7_LZB_EN setting of the build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int c_DIGITS   = 4;
    localparam int c_SCAN_DIV = 4;

`ifdef SEG7_LZB_EN
    localparam bit c_LZB = 1'b1;
`else
    localparam bit c_LZB = 1'b0;
`endif

    localparam logic [6:0] c_HEX [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        clr_n;
    logic        en;
    logic [15:0] dat;
    logic [3:0]  dp;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [3:0]  an;
    logic        tick;
    logic        frame;

    int n_checks = 0;
    int n_fail   = 0;

    seg7_scan_driver #(
        .DIGITS   (c_DIGITS),
        .SCAN_DIV (c_SCAN_DIV)
    ) dut (
        .clk    (clk),
        .clr_n  (clr_n),
        .en     (en),
        .dat    (dat),
        .dp     (dp),
        .seg    (seg),
        .seg_dp (seg_dp),
        .an     (an),
        .tick   (tick),
        .frame  (frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] exp_seg(input logic [15:0] s, input int d);
        logic [15:0] sh;
        sh = s >> (4*d);
        if (c_LZB && d > 0 && sh == 16'h0) return 7'h7F;
        return c_HEX[sh[3:0]];
    endfunction

    // Expected outputs at the k-th edge after reset release with en held
    // high and dp=0; 'snap' is the digit set loaded at the last frame wrap.
    task automatic scan_check(input int k, input logic [15:0] snap);
        int         d;
        logic [3:0] e_an;
        d = ((k - 1) / 4) % 4;
        e_an = 4'hF;
        e_an[d] = 1'b0;
        chk("scan_an",     {28'h0, an},     {28'h0, e_an});
        chk("scan_seg",    {25'h0, seg},    {25'h0, exp_seg(snap, d)});
        chk("scan_seg_dp", {31'h0, seg_dp}, 32'd1);
        chk("scan_tick",   {31'h0, tick},   {31'h0, (k % 4) == 0});
        chk("scan_frame",  {31'h0, frame},  {31'h0, (k % 16) == 0});
    endtask

    initial begin
        logic [15:0] snap_m;

        clr_n = 1'b0;
        en    = 1'b0;
        dat   = 16'h0;
        dp    = 4'h0;
        step(2);

        // Reset state
        chk("rst_an",     {28'h0, an},     32'hF);
        chk("rst_seg",    {25'h0, seg},    32'h7F);
        chk("rst_seg_dp", {31'h0, seg_dp}, 32'd1);
        chk("rst_tick",   {31'h0, tick},   32'd0);
        chk("rst_frame",  {31'h0, frame},  32'd0);

        // Two frames of 1234, then a mid-frame change to ABCD
        clr_n  = 1'b1;
        en     = 1'b1;
        dat    = 16'h1234;
        snap_m = 16'h0;
        for (int k = 1; k <= 64; k++) begin
            step(1);
            scan_check(k, snap_m);
            if (k % 16 == 0) snap_m = dat;
            if (k == 37) dat = 16'hABCD;
        end

        // en=0 mid-slot freezes everything
        step(2);
        chk("frz_pre_an", {28'h0, an}, 32'hE);
        en = 1'b0;
        for (int j = 0; j < 10; j++) begin
            step(1);
            chk("frz_an",   {28'h0, an},   32'hE);
            chk("frz_seg",  {25'h0, seg},  {25'h0, exp_seg(16'hABCD, 0)});
            chk("frz_tick", {31'h0, tick}, 32'd0);
        end
        en = 1'b1;
        step(1);
        chk("resume_tick0", {31'h0, tick}, 32'd0);
        step(1);
        chk("resume_tick1", {31'h0, tick}, 32'd1);
        chk("resume_an",    {28'h0, an},   32'hE);
        step(1);
        chk("resume_an_d",  {28'h0, an},   32'hD);

        // en dropped on the would-be wrap cycle defers the event
        step(2);
        en = 1'b0;
        step(1);
        chk("defer_tick0", {31'h0, tick}, 32'd0);
        en = 1'b1;
        step(1);
        chk("defer_tick1", {31'h0, tick}, 32'd1);
        chk("defer_an",    {28'h0, an},   32'hD);

        // Decimal point is live, not snapshotted
        dp = 4'b0100;
        step(1);
        chk("dp_an_b",  {28'h0, an},     32'hB);
        chk("dp_on",    {31'h0, seg_dp}, 32'd0);
        dp = 4'b0000;
        step(1);
        chk("dp_off",   {31'h0, seg_dp}, 32'd1);
        dp = 4'b1000;
        step(1);
        chk("dp_other", {31'h0, seg_dp}, 32'd1);
        step(2);
        chk("dp_an_7",  {28'h0, an},     32'h7);
        chk("dp_d3",    {31'h0, seg_dp}, 32'd0);
        dp = 4'b0000;

        // Asynchronous reset in the middle of a slot with an=B
        step(12);
        chk("pre_rst_an", {28'h0, an}, 32'hB);
        clr_n = 1'b0;
        #2;
        chk("arst_an",     {28'h0, an},     32'hF);
        chk("arst_seg",    {25'h0, seg},    32'h7F);
        chk("arst_seg_dp", {31'h0, seg_dp}, 32'd1);
        chk("arst_tick",   {31'h0, tick},   32'd0);
        chk("arst_frame",  {31'h0, frame},  32'd0);
        step(2);

        // Restart with full slots; value patterns for zero blanking
        clr_n  = 1'b1;
        en     = 1'b1;
        dat    = 16'h0000;
        snap_m = 16'h0;
        for (int k = 1; k <= 48; k++) begin
            step(1);
            scan_check(k, snap_m);
            if (k % 16 == 0) snap_m = dat;
            if (k == 4)  dat = 16'h0005;
            if (k == 20) dat = 16'h0105;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
